// File: rtl/sdram_rw_scheduler.sv
// Arbitrates the draw writer and the TFT refresh reader onto the single-port SDRAM core.
// The reader gets priority once per frame, and a watchdog releases grants the core never answers.
module sdram_rw_scheduler #(
  parameter int ADDR_W      = 24,
  parameter int TIMEOUT_CYC = 4096,
  parameter int TO_W        = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              frame_tick,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              wr_done,
  output logic [1:0]        sdram_call,
  output logic [ADDR_W-1:0] sdram_addr,
  input  logic [1:0]        sdram_done,
  output logic              busy,
  output logic              timeout_err,
  output logic [7:0]        frame_overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_RD  = 2'd1,
    GNT_WR  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t            state_q, state_d;
  logic [1:0]        call_q, call_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_done_q, rd_done_d;
  logic              wr_done_q, wr_done_d;
  logic              busy_q, busy_d;
  logic              terr_q, terr_d;
  logic [7:0]        ovr_q, ovr_d;
  logic              fp_q, fp_d;
  logic              last_wr_q, last_wr_d;
  logic [TO_W-1:0]   wd_q, wd_d;
  logic              pick_rd, pick_wr;
  logic              grant_rd, grant_wr;

  // Winner selection: pending frame, then round-robin, then the lone requester.
  always_comb begin
    pick_rd = 1'b0;
    pick_wr = 1'b0;
    if (fp_q && rd_req) begin
      pick_rd = 1'b1;
    end else if (rd_req && wr_req) begin
      if (last_wr_q) begin
        pick_rd = 1'b1;
      end else begin
        pick_wr = 1'b1;
      end
    end else if (rd_req) begin
      pick_rd = 1'b1;
    end else if (wr_req) begin
      pick_wr = 1'b1;
    end else begin
      pick_rd = 1'b0;
      pick_wr = 1'b0;
    end
    grant_rd = (state_q == IDLE) && en && pick_rd;
    grant_wr = (state_q == IDLE) && en && pick_wr;
  end

  // Next-state and next-output computation for the grant sequencer.
  always_comb begin
    state_d   = state_q;
    call_d    = call_q;
    addr_d    = addr_q;
    rd_done_d = 1'b0;
    wr_done_d = 1'b0;
    terr_d    = terr_q;
    last_wr_d = last_wr_q;
    wd_d      = wd_q;
    case (state_q)
      IDLE: begin
        if (grant_rd) begin
          state_d   = GNT_RD;
          call_d    = 2'b01;
          addr_d    = rd_addr;
          last_wr_d = 1'b0;
          wd_d      = '0;
        end else if (grant_wr) begin
          state_d   = GNT_WR;
          call_d    = 2'b10;
          addr_d    = wr_addr;
          last_wr_d = 1'b1;
          wd_d      = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GNT_RD: begin
        if (sdram_done[0] || (wd_q == WD_LAST)) begin
          state_d   = RELEASE;
          call_d    = 2'b00;
          rd_done_d = 1'b1;
          terr_d    = terr_q | ~sdram_done[0];
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      GNT_WR: begin
        if (sdram_done[1] || (wd_q == WD_LAST)) begin
          state_d   = RELEASE;
          call_d    = 2'b00;
          wr_done_d = 1'b1;
          terr_d    = terr_q | ~sdram_done[1];
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        call_d  = 2'b00;
      end
    endcase

    // A tick coinciding with a read grant must survive it, so the tick wins.
    if (frame_tick) begin
      fp_d = 1'b1;
    end else if (grant_rd) begin
      fp_d = 1'b0;
    end else begin
      fp_d = fp_q;
    end
    if (frame_tick && fp_q && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end else begin
      ovr_d = ovr_q;
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      call_q    <= 2'b00;
      addr_q    <= '0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      busy_q    <= 1'b0;
      terr_q    <= 1'b0;
      ovr_q     <= 8'd0;
      fp_q      <= 1'b0;
      last_wr_q <= 1'b1;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      call_q    <= call_d;
      addr_q    <= addr_d;
      rd_done_q <= rd_done_d;
      wr_done_q <= wr_done_d;
      busy_q    <= busy_d;
      terr_q    <= terr_d;
      ovr_q     <= ovr_d;
      fp_q      <= fp_d;
      last_wr_q <= last_wr_d;
      wd_q      <= wd_d;
    end
  end

  assign sdram_call    = call_q;
  assign sdram_addr    = addr_q;
  assign rd_done       = rd_done_q;
  assign wr_done       = wr_done_q;
  assign busy          = busy_q;
  assign timeout_err   = terr_q;
  assign frame_overrun = ovr_q;

endmodule
